// File: rtl/mmio_timer.sv
// mmio_timer: Avalon-MM RISC-V machine timer with one-wait-state reads
module mmio_timer #(
   parameter int ADDR_W     = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic [31:0]       readdata,
   output logic              waitrequest,
   output logic              timer_irq
);
   typedef enum logic {S_IDLE, S_RESP} state_t;
   state_t                r_state, w_state_nxt;
   logic [63:0]           r_mtime, r_mtimecmp, w_mtime_inc, w_mtime_nxt;
   logic [PRESCALE_W-1:0] r_pcnt, r_prescale;
   logic [1:0]            r_ctrl;
   logic [31:0]           r_hi_shadow, r_readdata_q, w_rdata, w_word;
   logic                  w_tick, w_wr, w_rd;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] m;
      m = old;
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i+:8] = d[8*i+:8];
      return m;
   endfunction

   assign w_word      = 32'(address) >> 2;
   assign w_rd        = (r_state == S_IDLE) && read;
   assign w_wr        = write && !read;
   assign w_tick      = r_ctrl[0] && (r_pcnt == r_prescale);
   assign w_mtime_inc = r_mtime + 64'(w_tick);
   assign readdata    = r_readdata_q;

   // Bus write/read overlap is a host bug; the read wins and the write is dropped
   assert property (@(posedge clk) disable iff (rst) !(read && write));

   // Read FSM next state and stall: one wait cycle per accepted read
   always_comb begin
      w_state_nxt = w_rd ? S_RESP : S_IDLE;
      waitrequest = w_rd;
   end

   // Register file read decode; mtime_hi returns the shadow captured by the last mtime_lo read
   always_comb begin
      w_rdata = '0;
      case (w_word)
         32'd0:   w_rdata = r_mtime[31:0];
         32'd1:   w_rdata = r_hi_shadow;
         32'd2:   w_rdata = r_mtimecmp[31:0];
         32'd3:   w_rdata = r_mtimecmp[63:32];
         32'd4:   w_rdata = 32'(r_ctrl);
         32'd5:   w_rdata = 32'(r_prescale);
         default: w_rdata = '0;
      endcase
   end

   // Written mtime bytes override the ticked value; unwritten bytes keep the increment
   always_comb begin
      w_mtime_nxt[31:0]  = (w_wr && w_word == 32'd0) ? merge(w_mtime_inc[31:0], writedata, byteenable) : w_mtime_inc[31:0];
      w_mtime_nxt[63:32] = (w_wr && w_word == 32'd1) ? merge(w_mtime_inc[63:32], writedata, byteenable) : w_mtime_inc[63:32];
   end

   // Read FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Timer state, prescaler, compare register, control and interrupt
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mtime    <= '0;
         r_pcnt     <= '0;
         r_mtimecmp <= '1;
         r_ctrl     <= '0;
         r_prescale <= '0;
         timer_irq  <= 1'b0;
      end else begin
         r_mtime <= w_mtime_nxt;
         r_pcnt  <= (w_wr && w_word == 32'd5) ? '0 : !r_ctrl[0] ? r_pcnt : w_tick ? '0 : r_pcnt + 1'b1;
         if (w_wr && w_word == 32'd2) r_mtimecmp[31:0]  <= merge(r_mtimecmp[31:0], writedata, byteenable);
         if (w_wr && w_word == 32'd3) r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], writedata, byteenable);
         if (w_wr && w_word == 32'd4) r_ctrl     <= 2'(merge(32'(r_ctrl), writedata, byteenable));
         if (w_wr && w_word == 32'd5) r_prescale <= PRESCALE_W'(merge(32'(r_prescale), writedata, byteenable));
         timer_irq <= r_ctrl[1] && (r_mtime >= r_mtimecmp);
      end
   end

   // Read data capture in the wait cycle; an mtime_lo read snapshots the high word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_readdata_q <= '0;
         r_hi_shadow  <= '0;
      end else if (w_rd) begin
         r_readdata_q <= w_rdata;
         if (w_word == 32'd0) r_hi_shadow <= r_mtime[63:32];
      end
   end
endmodule
